// File: rtl/rt2ic_enqueue_arbiter.sv
// Round-robin enqueue arbiter feeding the RT->IC ray queue.
// Grants at most one core per cycle and reserves queue credits at decision time.
module rt2ic_enqueue_arbiter #(
  parameter  int NUM_RT = 4,
  parameter  int DEPTH  = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RT-1:0] req_RT,
  output logic [NUM_RT-1:0] ack_RT,
  output logic              q_en_PD,
  output logic [NUM_RT-1:0] core_id_PD,
  input  logic              dequeue_IC,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full,
  output logic              empty,
  output logic              err_underflow
);

  localparam int               PTR_W   = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W:0]   NUM_C   = (PTR_W + 1)'(NUM_RT);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NUM_RT - 1);

  logic [NUM_RT-1:0] ack_q, ack_d;
  logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]  occupancy_q, occupancy_d;
  logic              errUnderflow_q, errUnderflow_d;

  logic [NUM_RT-1:0] eligible;
  logic [PTR_W:0]    sum;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  winner;
  logic              found;
  logic              underflow;
  logic              popValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q          <= '0;
      rrPtr_q        <= '0;
      occupancy_q    <= '0;
      errUnderflow_q <= 1'b0;
    end else begin
      ack_q          <= ack_d;
      rrPtr_q        <= rrPtr_d;
      occupancy_q    <= occupancy_d;
      errUnderflow_q <= errUnderflow_d;
    end
  end

  // The core being acked this cycle still holds req, so it is masked out of the search.
  always_comb begin
    eligible = req_RT & ~ack_q;
    sum      = '0;
    idx      = '0;
    winner   = '0;
    found    = 1'b0;
    if (occupancy_q < DEPTH_C) begin
      for (int i = 0; i < NUM_RT; i++) begin
        sum = {1'b0, rrPtr_q} + (PTR_W + 1)'(i);
        if (sum >= NUM_C) sum = sum - NUM_C;
        idx = sum[PTR_W-1:0];
        if (!found && eligible[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  always_comb begin
    ack_d   = '0;
    rrPtr_d = rrPtr_q;
    if (found) begin
      ack_d[winner] = 1'b1;
      rrPtr_d       = (winner == LAST_C) ? '0 : winner + 1'b1;
    end
  end

  // A pop against an empty count is ignored and flagged; the counter never wraps.
  always_comb begin
    underflow      = dequeue_IC && (occupancy_q == '0);
    popValid       = dequeue_IC && !underflow;
    errUnderflow_d = errUnderflow_q | underflow;
    occupancy_d    = occupancy_q;
    case ({found, popValid})
      2'b10:   occupancy_d = occupancy_q + 1'b1;
      2'b01:   occupancy_d = occupancy_q - 1'b1;
      default: occupancy_d = occupancy_q;
    endcase
  end

  assign ack_RT        = ack_q;
  assign core_id_PD    = ack_q;
  assign q_en_PD       = |ack_q;
  assign occupancy     = occupancy_q;
  assign full          = (occupancy_q == DEPTH_C);
  assign empty         = (occupancy_q == '0);
  assign err_underflow = errUnderflow_q;

endmodule
